gb_wave_ram_controller: RTL and testbench

Owns the 16-byte Channel 3 wave RAM (0xFF30-0xFF3F) and arbitrates its single access port between CPU register accesses and Channel 3 sample fetches. Supplies the channel with a registered sample byte for the byte address the channel is currently playing. Applies the DMG access rules while the channel is on: CPU reads see the byte being played, and CPU writes land on that byte. Sits between the APU register bus decode and the custom wave channel.

---
 rtl/gb_wave_ram_controller.sv | 128 ++++++++++++
 tb/tb_gb_wave_ram_controller.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gb_wave_ram_controller.sv
// Channel 3 wave RAM: a 16-byte store whose single access port is shared between
// CPU register accesses and the channel's sample fetches.
module gb_wave_ram_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [3:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_ready,
  output logic       cpu_rvalid,
  output logic [7:0] cpu_rdata,
  input  logic       ch_on,
  input  logic [3:0] ch_addr,
  output logic [7:0] wave_data
);

  typedef enum logic [1:0] {IDLE, FETCH, CPU} state_t;

  state_t     state_reg, state_next;
  logic [7:0] mem_reg [16];
  logic [3:0] fetch_addr_reg;
  logic       init_reg;
  logic       ch_on_reg;
  logic       pend_reg;
  logic       pend_we_reg;
  logic [3:0] pend_addr_reg;
  logic [7:0] pend_wdata_reg;

  logic       fetch_pend;
  logic       mem_we;
  logic [3:0] mem_waddr;
  logic [3:0] mem_raddr;
  logic [7:0] mem_rdata;

  assign cpu_ready = ~pend_reg;

  // A fetch in progress already tracks ch_addr, so the compare only matters outside FETCH.
  always_comb begin
    fetch_pend = (state_reg != FETCH) &&
                 (init_reg || (ch_on && !ch_on_reg) || (ch_addr != fetch_addr_reg));
  end

  always_comb begin
    state_next = IDLE;
    if (fetch_pend) begin
      state_next = FETCH;
    end else if (pend_reg && state_reg != CPU) begin
      state_next = CPU;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // While the channel plays, CPU writes land on the byte being played.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = pend_addr_reg;
    if (state_reg == CPU && pend_we_reg) begin
      mem_we    = 1'b1;
      mem_waddr = ch_on ? fetch_addr_reg : pend_addr_reg;
    end
  end

  assign mem_raddr = (state_reg == FETCH) ? ch_addr : pend_addr_reg;
  assign mem_rdata = mem_reg[mem_raddr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) begin
        mem_reg[i] <= 8'h00;
      end
    end else if (mem_we) begin
      mem_reg[mem_waddr] <= pend_wdata_reg;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_addr_reg <= 4'h0;
      init_reg       <= 1'b1;
      ch_on_reg      <= 1'b0;
      pend_reg       <= 1'b0;
      pend_we_reg    <= 1'b0;
      pend_addr_reg  <= 4'h0;
      pend_wdata_reg <= 8'h00;
      wave_data      <= 8'h00;
      cpu_rdata      <= 8'h00;
      cpu_rvalid     <= 1'b0;
    end else begin
      init_reg   <= 1'b0;
      ch_on_reg  <= ch_on;
      cpu_rvalid <= 1'b0;

      if (!pend_reg && cpu_req) begin
        pend_reg       <= 1'b1;
        pend_we_reg    <= cpu_we;
        pend_addr_reg  <= cpu_addr;
        pend_wdata_reg <= cpu_wdata;
      end

      case (state_reg)
        FETCH: begin
          wave_data      <= mem_rdata;
          fetch_addr_reg <= ch_addr;
        end
        CPU: begin
          pend_reg <= 1'b0;
          if (!pend_we_reg) begin
            cpu_rvalid <= 1'b1;
            cpu_rdata  <= ch_on ? wave_data : mem_rdata;
          end else if (ch_on || pend_addr_reg == fetch_addr_reg) begin
            wave_data <= pend_wdata_reg;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gb_wave_ram_controller.sv
// Bench for gb_wave_ram_controller: directed scenarios with literal expectations,
// then random traffic checked every cycle against a transaction-level model.
module tb_gb_wave_ram_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cpu_req = 1'b0;
  logic       cpu_we = 1'b0;
  logic [3:0] cpu_addr = 4'h0;
  logic [7:0] cpu_wdata = 8'h00;
  logic       cpu_ready;
  logic       cpu_rvalid;
  logic [7:0] cpu_rdata;
  logic       ch_on = 1'b0;
  logic [3:0] ch_addr = 4'h0;
  logic [7:0] wave_data;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  gb_wave_ram_controller dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ready (cpu_ready),
    .cpu_rvalid(cpu_rvalid),
    .cpu_rdata (cpu_rdata),
    .ch_on     (ch_on),
    .ch_addr   (ch_addr),
    .wave_data (wave_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: one outstanding CPU request, the byte the channel last received, and
  // which requester owns the port in the current cycle (0 none, 1 fetch, 2 cpu).
  typedef struct packed {
    bit       we;
    bit [3:0] a;
    bit [7:0] d;
  } req_t;

  req_t     q[$];
  bit [7:0] m_mem [16];
  bit [7:0] m_wave, m_rdata;
  bit       m_rvalid, m_ready, m_first, m_prev_on;
  bit [3:0] m_fetch_addr;
  int       m_grant;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    q.delete();
    m_wave = 8'h00;
    m_rdata = 8'h00;
    m_rvalid = 1'b0;
    m_ready = 1'b1;
    m_first = 1'b1;
    m_prev_on = 1'b0;
    m_fetch_addr = 4'h0;
    m_grant = 0;
  endtask

  task automatic model_step();
    bit   want_fetch, had_req;
    int   nxt;
    req_t r;
    want_fetch = (m_grant != 1) &&
                 (m_first || (ch_on && !m_prev_on) || (ch_addr != m_fetch_addr));
    had_req = (q.size() != 0);
    nxt = want_fetch ? 1 : ((had_req && m_grant != 2) ? 2 : 0);
    m_rvalid = 1'b0;
    if (m_grant == 1) begin
      m_wave = m_mem[ch_addr];
      m_fetch_addr = ch_addr;
    end else if (m_grant == 2) begin
      r = q.pop_front();
      if (!r.we) begin
        m_rvalid = 1'b1;
        m_rdata = ch_on ? m_wave : m_mem[r.a];
      end else if (ch_on) begin
        m_mem[m_fetch_addr] = r.d;
        m_wave = r.d;
      end else begin
        m_mem[r.a] = r.d;
        if (r.a == m_fetch_addr) m_wave = r.d;
      end
    end
    if (!had_req && cpu_req === 1'b1) begin
      r.we = cpu_we;
      r.a = cpu_addr;
      r.d = cpu_wdata;
      q.push_back(r);
    end
    m_first = 1'b0;
    m_prev_on = ch_on;
    m_grant = nxt;
    m_ready = (q.size() == 0);
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cpu_ready", cpu_ready, m_ready);
      chk("cpu_rvalid", cpu_rvalid, m_rvalid);
      chk("cpu_rdata", cpu_rdata, m_rdata);
      chk("wave_data", wave_data, m_wave);
    end
  end

  // Issues one CPU access; lat counts cycles from capture to completion, low counts
  // cycles with cpu_ready low. new_ch >= 0 moves ch_addr right after the capture edge.
  task automatic cpu_op(input bit we, input logic [3:0] a, input logic [7:0] d,
                        input int new_ch, output logic [7:0] rd, output int lat,
                        output int low);
    int guard = 0;
    rd = 8'h00;
    lat = 0;
    low = 0;
    while (!cpu_ready && guard < 16) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!cpu_ready) chk("op_ready_timeout", cpu_ready, 1);
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_addr = a;
    cpu_wdata = d;
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    if (new_ch >= 0) ch_addr = new_ch[3:0];
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (!cpu_ready) low++;
      if (we ? cpu_ready : cpu_rvalid) begin
        rd = cpu_rdata;
        break;
      end
      lat++;
      @(posedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] rd;
    int lat, low, since;

    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    #1 reset = 1'b1;

    // Reset release: byte 0 fetched, nothing pending.
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_wave", wave_data, 8'h00);
    chk("rst_ready", cpu_ready, 1);
    @(posedge clk);
    #1;

    // Uncontended write then read.
    cpu_op(1'b1, 4'd3, 8'hA5, -1, rd, lat, low);
    chk("wr_lat", lat, 2);
    chk("wr_ready_low", low, 2);
    cpu_op(1'b0, 4'd3, 8'h00, -1, rd, lat, low);
    chk("rd_lat", lat, 2);
    chk("rd_ready_low", low, 2);
    chk("rd_data", rd, 8'hA5);

    // Channel fetches follow ch_addr two cycles later.
    cpu_op(1'b1, 4'd5, 8'h3C, -1, rd, lat, low);
    cpu_op(1'b1, 4'd6, 8'h7E, -1, rd, lat, low);
    ch_addr = 4'd5;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("fetch5", wave_data, 8'h3C);
    @(posedge clk);
    #1 ch_addr = 4'd6;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("fetch6", wave_data, 8'h7E);
    @(posedge clk);
    #1;

    // ch_addr moves in the cycle the read is captured: fetch goes first.
    cpu_op(1'b0, 4'd5, 8'h00, 3, rd, lat, low);
    chk("coll_lat", lat, 3);
    chk("coll_data", rd, 8'h3C);
    chk("coll_wave", wave_data, 8'hA5);

    // Playing channel: reads see the played byte, writes land on it.
    cpu_op(1'b1, 4'd9, 8'h11, -1, rd, lat, low);
    ch_addr = 4'd9;
    ch_on = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("on_wave", wave_data, 8'h11);
    @(posedge clk);
    #1;
    cpu_op(1'b0, 4'd2, 8'h00, -1, rd, lat, low);
    chk("on_rd", rd, 8'h11);
    cpu_op(1'b1, 4'd2, 8'hF0, -1, rd, lat, low);
    chk("on_wr_wave", wave_data, 8'hF0);
    ch_on = 1'b0;
    cpu_op(1'b0, 4'd9, 8'h00, -1, rd, lat, low);
    chk("on_wr_redirect", rd, 8'hF0);
    cpu_op(1'b0, 4'd2, 8'h00, -1, rd, lat, low);
    chk("on_wr_untouched", rd, 8'h00);

    // Reset with a write pending.
    cpu_req = 1'b1;
    cpu_we = 1'b1;
    cpu_addr = 4'd4;
    cpu_wdata = 8'h55;
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("rstmid_rvalid", cpu_rvalid, 0);
    chk("rstmid_ready", cpu_ready, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rstmid_ready_after", cpu_ready, 1);
    @(posedge clk);
    #1;
    cpu_op(1'b0, 4'd4, 8'h00, -1, rd, lat, low);
    chk("rstmid_mem4", rd, 8'h00);
    cpu_op(1'b0, 4'd3, 8'h00, -1, rd, lat, low);
    chk("rstmid_mem3", rd, 8'h00);

    // Random traffic; the model checks every cycle.
    since = 0;
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      cpu_req = 1'($urandom_range(0, 1));
      cpu_we = 1'($urandom_range(0, 1));
      cpu_addr = 4'($urandom);
      cpu_wdata = 8'($urandom);
      if ($urandom_range(0, 31) == 0) ch_on = ~ch_on;
      if (since >= 2 && $urandom_range(0, 2) == 0) begin
        ch_addr = ($urandom_range(0, 3) == 0) ? 4'($urandom) : ch_addr + 4'd1;
        since = 0;
      end else begin
        since++;
      end
      @(posedge clk);
      #1;
    end

    cpu_req = 1'b0;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
